mandelbrot_iter_ctrl: RTL and testbench

//  Sequential controller wrapped around the combinational Mandelbrot step (mandelbrot).
//  - Accepts one point c = (p_re, p_im) per handshake.
//  - Iterates z <= z^2 + c from z = 0, one step per clock.
//  - Returns the escape iteration count, or max_iter if the point never escapes.
//  - Sits between the pixel/coordinate generator (upstream) and the colour mapper (downstream).

---
 rtl/mandelbrot_iter_ctrl_if.sv | 37 +++
 rtl/mandelbrot_iter_ctrl.sv | 157 +++++++++++++++
 tb/tb_mandelbrot_iter_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_iter_ctrl_if.sv
// Handshake bundle for the Mandelbrot iteration controller: point in, escape count out.
// The abort line exists only when MANDEL_ABORT_EN is defined.
interface mandelbrot_iter_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH:0]   p_re;
  logic signed [WIDTH:0]   p_im;
  logic [ITER_W-1:0]       max_iter;
  logic                    out_valid;
  logic                    out_ready;
  logic [ITER_W-1:0]       out_iter;
  logic                    out_escaped;
`ifdef MANDEL_ABORT_EN
  logic                    abort;
`endif

  // Controller side
  modport slave (
    input  in_valid, p_re, p_im, max_iter, out_ready,
`ifdef MANDEL_ABORT_EN
    input  abort,
`endif
    output in_ready, out_valid, out_iter, out_escaped
  );

  // Generator / colour-mapper side
  modport master (
    output in_valid, p_re, p_im, max_iter, out_ready,
`ifdef MANDEL_ABORT_EN
    output abort,
`endif
    input  in_ready, out_valid, out_iter, out_escaped
  );
endinterface

// File: rtl/mandelbrot_iter_ctrl.sv
// Sequential Mandelbrot escape-time controller: iterates z <= z^2 + c, one step per clock.
// Optional feature: MANDEL_ABORT_EN adds an abort input that drops the point in flight.
module mandelbrot_iter_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mandelbrot_iter_ctrl_if.slave bus
);

  localparam int FRAC  = 25;
  localparam int RW    = WIDTH + 1;
  localparam int PW    = 2 * WIDTH + 2;
  localparam int MAG_W = PW + 1;
  // 4.0 expressed in the 2*FRAC fractional bits of a squared coordinate
  localparam logic [MAG_W-1:0] ESC_LIMIT = MAG_W'(1) << (2 * FRAC + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic signed [WIDTH:0] z_re_r, z_re_s;
  logic signed [WIDTH:0] z_im_r, z_im_s;
  logic signed [WIDTH:0] p_re_r, p_re_s;
  logic signed [WIDTH:0] p_im_r, p_im_s;
  logic [ITER_W-1:0]     max_iter_r, max_iter_s;
  logic [ITER_W-1:0]     cnt_r, cnt_s;
  logic [ITER_W-1:0]     out_iter_r, out_iter_s;
  logic                  out_escaped_r, out_escaped_s;
  logic                  out_valid_r, out_valid_s;

  logic signed [PW-1:0]  z_re_x_s, z_im_x_s;
  logic signed [PW-1:0]  re_sq_s, im_sq_s, cross_s;
  logic [MAG_W-1:0]      mag_s;
  logic signed [WIDTH:0] step_re_s, step_im_s;
  logic                  conv_s;
  logic                  abort_s;

`ifdef MANDEL_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  assign bus.in_ready    = (state_r == IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.out_iter    = out_iter_r;
  assign bus.out_escaped = out_escaped_r;

  // Combinational step: next z and the |z|^2 > 4.0 escape test on the current z
  always_comb begin
    z_re_x_s  = {{RW{z_re_r[WIDTH]}}, z_re_r};
    z_im_x_s  = {{RW{z_im_r[WIDTH]}}, z_im_r};
    re_sq_s   = z_re_x_s * z_re_x_s;
    im_sq_s   = z_im_x_s * z_im_x_s;
    cross_s   = z_re_x_s * z_im_x_s;
    mag_s     = {1'b0, re_sq_s} + {1'b0, im_sq_s};
    // Rescale back to FRAC bits and wrap to the coordinate width; 2*re*im is one less shift
    step_re_s = RW'((re_sq_s - im_sq_s) >>> FRAC) + p_re_r;
    step_im_s = RW'(cross_s >>> (FRAC - 1)) + p_im_r;
    conv_s    = (mag_s > ESC_LIMIT) ? 1'b0 : 1'b1;
  end

  // Next-state and datapath update for the IDLE -> ITER -> DONE sequence
  always_comb begin
    state_s       = state_r;
    z_re_s        = z_re_r;
    z_im_s        = z_im_r;
    p_re_s        = p_re_r;
    p_im_s        = p_im_r;
    max_iter_s    = max_iter_r;
    cnt_s         = cnt_r;
    out_iter_s    = out_iter_r;
    out_escaped_s = out_escaped_r;
    out_valid_s   = out_valid_r;
    case (state_r)
      IDLE: begin
        out_valid_s = 1'b0;
        if (bus.in_valid) begin
          p_re_s     = bus.p_re;
          p_im_s     = bus.p_im;
          max_iter_s = bus.max_iter;
          z_re_s     = '0;
          z_im_s     = '0;
          cnt_s      = '0;
          state_s    = ITER;
        end else begin
          state_s = IDLE;
        end
      end
      ITER: begin
        if (abort_s) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else if (!conv_s) begin
          out_iter_s    = cnt_r;
          out_escaped_s = 1'b1;
          out_valid_s   = 1'b1;
          state_s       = DONE;
        end else if (cnt_r == max_iter_r) begin
          out_iter_s    = cnt_r;
          out_escaped_s = 1'b0;
          out_valid_s   = 1'b1;
          state_s       = DONE;
        end else begin
          z_re_s = step_re_s;
          z_im_s = step_im_s;
          cnt_s  = cnt_r + ITER_W'(1);
        end
      end
      DONE: begin
        if (abort_s || bus.out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        out_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      z_re_r        <= '0;
      z_im_r        <= '0;
      p_re_r        <= '0;
      p_im_r        <= '0;
      max_iter_r    <= '0;
      cnt_r         <= '0;
      out_iter_r    <= '0;
      out_escaped_r <= 1'b0;
      out_valid_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      z_re_r        <= z_re_s;
      z_im_r        <= z_im_s;
      p_re_r        <= p_re_s;
      p_im_r        <= p_im_s;
      max_iter_r    <= max_iter_s;
      cnt_r         <= cnt_s;
      out_iter_r    <= out_iter_s;
      out_escaped_r <= out_escaped_s;
      out_valid_r   <= out_valid_s;
    end
  end

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Self-checking bench for mandelbrot_iter_ctrl: directed points, random points against a
// wide-integer escape-time model, backpressure, reset mid-run and (with MANDEL_ABORT_EN) abort.
module tb_mandelbrot_iter_ctrl;

  localparam int WIDTH  = 32;
  localparam int ITER_W = 16;
  localparam int FRAC   = 25;
  localparam int BUDGET = 2000;
  localparam logic signed [127:0] LIMIT = 128'sd4 <<< (2 * FRAC);

  typedef logic signed [WIDTH:0] coord_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mandelbrot_iter_ctrl_if #(.WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();

  mandelbrot_iter_ctrl #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Escape-time reference: plain wide-integer arithmetic on the fixed-point values
  function automatic void model(input coord_t cr, input coord_t ci, input int maxi,
                                output int n, output bit esc);
    logic signed [127:0] zr, zi, nr, ni, mag;
    coord_t tr, ti;
    zr = '0; zi = '0; n = maxi; esc = 1'b0;
    for (int k = 0; k <= maxi; k++) begin
      mag = zr * zr + zi * zi;
      if (mag > LIMIT) begin n = k; esc = 1'b1; break; end
      if (k == maxi) begin n = k; break; end
      nr = ((zr * zr - zi * zi) >>> FRAC) + cr;
      ni = ((2 * zr * zi) >>> FRAC) + ci;
      tr = nr[WIDTH:0];
      ti = ni[WIDTH:0];
      zr = tr;
      zi = ti;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a point for one accept edge; returns sampled just after that edge
  task automatic send_point(input coord_t re, input coord_t im, input int maxi);
    bus.p_re     = re;
    bus.p_im     = im;
    bus.max_iter = maxi[ITER_W-1:0];
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < BUDGET) begin
      step();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.p_re = '0; bus.p_im = '0; bus.max_iter = '0;
`ifdef MANDEL_ABORT_EN
    bus.abort = 1'b0;
`endif
    step(); step();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_iter !== 16'd0 || bus.out_escaped !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_iter=%0d esc=%b, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_iter, bus.out_escaped);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_known_points();
    coord_t re_t [4];
    coord_t im_t [4];
    int     mx_t [4];
    int     it_t [4];
    bit     es_t [4];
    bit     known[4];
    int     lat, n;
    bit     esc;
    re_t[0] = 33'sd0;          im_t[0] = 33'sd0;       mx_t[0] = 255; it_t[0] = 255; es_t[0] = 1'b0; known[0] = 1'b1;
    re_t[1] = 33'h004000000;   im_t[1] = 33'sd0;       mx_t[1] = 255; it_t[1] = 2;   es_t[1] = 1'b1; known[1] = 1'b1;
    re_t[2] = -33'sd45214597;  im_t[2] = 33'sd2097152; mx_t[2] = 255; it_t[2] = 0;   es_t[2] = 1'b0; known[2] = 1'b0;
    re_t[3] = 33'sd12345678;   im_t[3] = -33'sd9876;   mx_t[3] = 0;   it_t[3] = 0;   es_t[3] = 1'b0; known[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model(re_t[i], im_t[i], mx_t[i], n, esc);
      if (!known[i]) begin it_t[i] = n; es_t[i] = esc; end
      send_point(re_t[i], im_t[i], mx_t[i]);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL known%0d_busy: in_ready=%b, required 0", i, bus.in_ready);
      end
      wait_valid(lat);
      n_checks++;
      if (lat !== it_t[i] + 1) begin
        n_fail++;
        $display("FAIL known%0d_latency: got %0d cycles, required %0d", i, lat, it_t[i] + 1);
      end
      n_checks++;
      if (bus.out_iter !== it_t[i][ITER_W-1:0] || bus.out_escaped !== es_t[i]) begin
        n_fail++;
        $display("FAIL known%0d_result: iter=%0d esc=%b, required iter=%0d esc=%b",
                 i, bus.out_iter, bus.out_escaped, it_t[i], es_t[i]);
      end
      if (!known[i]) $display("golden point: model iter=%0d esc=%b", n, esc);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL known%0d_release: out_valid=%b in_ready=%b, required 0 1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    send_point(coord_t'($urandom), coord_t'($urandom), 0);
    wait_valid(lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL hold_latency: got %0d, required 1", lat);
    end
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.p_re = coord_t'($urandom);
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_iter !== 16'd0 || bus.out_escaped !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: out_valid=%b iter=%0d esc=%b in_ready=%b, required 1 0 0 0",
                 c, bus.out_valid, bus.out_iter, bus.out_escaped, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int seen[$];
    int iters[$];
    int guard;
    bus.p_re = 33'h004000000; bus.p_im = '0; bus.max_iter = 16'd10;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.out_valid) begin seen.push_back(c); iters.push_back(int'(bus.out_iter)); end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (seen.size() < 5) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required at least 5", seen.size());
    end
    for (int k = 1; k < seen.size(); k++) begin
      n_checks++;
      if (seen[k] - seen[k-1] !== 5 || iters[k] !== 2) begin
        n_fail++;
        $display("FAIL b2b_period%0d: interval=%0d iter=%0d, required 5 and 2", k, seen[k] - seen[k-1], iters[k]);
      end
    end
    guard = 0;
    while (!(bus.in_ready && !bus.out_valid) && guard < BUDGET) begin step(); guard++; end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int results, got_iter;
    bit got_esc;
    send_point('0, '0, 255);
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_iter !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_state: in_ready=%b out_valid=%b iter=%0d, required 1 0 0", bus.in_ready, bus.out_valid, bus.out_iter);
    end
    bus.out_ready = 1'b1;
    send_point(33'h004000000, '0, 255);
    results = 0; got_iter = -1; got_esc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.out_valid) begin results++; got_iter = int'(bus.out_iter); got_esc = bus.out_escaped; end
      step();
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (results !== 1 || got_iter !== 2 || got_esc !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_result: %0d results iter=%0d esc=%b, required 1 result iter=2 esc=1", results, got_iter, got_esc);
    end
  endtask

  task automatic test_random();
    coord_t re, im;
    int maxi, n, lat, hold;
    bit esc;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        re = coord_t'($urandom); im = coord_t'($urandom);
      end else begin
        re = coord_t'(int'($urandom_range(0, 167772160)) - 83886080);
        im = coord_t'(int'($urandom_range(0, 100663296)) - 50331648);
      end
      maxi = int'($urandom_range(0, 60));
      model(re, im, maxi, n, esc);
      send_point(re, im, maxi);
      // garbage on the input side while busy must not disturb the latched point
      lat = 0;
      while (!bus.out_valid && lat < BUDGET) begin
        bus.p_re = coord_t'($urandom); bus.p_im = coord_t'($urandom);
        bus.max_iter = 16'($urandom);
        step();
        lat++;
      end
      if (!bus.out_valid) lat = -1;
      n_checks++;
      if (lat !== n + 1 || bus.out_iter !== n[ITER_W-1:0] || bus.out_escaped !== esc) begin
        n_fail++;
        $display("FAIL random%0d: lat=%0d iter=%0d esc=%b, required lat=%0d iter=%0d esc=%b",
                 i, lat, bus.out_iter, bus.out_escaped, n + 1, n, esc);
      end
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_iter !== n[ITER_W-1:0]) begin
          n_fail++;
          $display("FAIL random%0d_stall: out_valid=%b iter=%0d, required 1 %0d", i, bus.out_valid, bus.out_iter, n);
        end
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
  endtask

`ifdef MANDEL_ABORT_EN
  task automatic test_abort();
    int pulses, lat;
    send_point('0, '0, 255);
    repeat (4) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.out_valid) pulses++;
      step();
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_silent: got %0d valid cycles, required 0", pulses);
    end
    bus.abort = 1'b1;
    send_point(33'h004000000, '0, 255);
    bus.abort = 1'b0;
    wait_valid(lat);
    n_checks++;
    if (lat !== 3 || bus.out_iter !== 16'd2 || bus.out_escaped !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_next: lat=%0d iter=%0d esc=%b, required 3 2 1", lat, bus.out_iter, bus.out_escaped);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_known_points();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MANDEL_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
